monster_motion_ctrl: RTL and testbench



---
 rtl/monster_motion_ctrl.sv | 178 +++++++++++++++++
 tb/tb_monster_motion_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/monster_motion_ctrl.sv
// rtl/monster_motion_ctrl.sv - per-frame monster sprite motion, hit-flash and death sequencer
// Movement advances once every FRAME_DIV frames; X bounces between X_MIN and X_MAX-M_WIDTH.
module monster_motion_ctrl #(
  parameter int X_INIT       = 135,
  parameter int Y_INIT       = 85,
  parameter int M_WIDTH      = 31,
  parameter int STEP_X       = 10,
  parameter int STEP_Y       = 10,
  parameter int X_MIN        = 23,
  parameter int X_MAX        = 636,
  parameter int FRAME_DIV    = 3,
  parameter int HP_INIT      = 3,
  parameter int FLASH_FRAMES = 8
) (
  input  logic       Pclk,
  input  logic       rst_n,
  input  logic [9:0] xx,
  input  logic [9:0] yy,
  input  logic       start,
  input  logic       hit,
  input  logic       restart,
  output logic [9:0] M1X,
  output logic [9:0] M1Y,
  output logic       dir,
  output logic [2:0] hp,
  output logic       sprite_visible,
  output logic       dead,
  output logic       frame_tick
);

  typedef enum logic [2:0] {S_IDLE, S_MOVE_L, S_MOVE_R, S_FLASH, S_DEAD} state_t;

  localparam logic [3:0]  FDIV_LAST  = 4'(FRAME_DIV - 1);
  localparam logic [3:0]  FLASH_LAST = 4'(FLASH_FRAMES - 1);
  localparam logic [10:0] L_EDGE     = 11'(X_MIN + STEP_X);
  localparam logic [10:0] R_REACH    = 11'(M_WIDTH + STEP_X);

  state_t      state_q, state_d;
  logic        match_q, tick_q, tick_d;
  logic [3:0]  fdiv_q, fdiv_d, flash_q, flash_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dir_q, dir_d, vis_q, vis_d, ret_q, ret_d;
  logic [2:0]  hp_q, hp_d;

  logic        match, moving, move_tick, flash_done, hit_ok;
  logic [10:0] x_ext;

  assign match      = (xx == 10'd639) && (yy == 10'd479);
  assign moving     = (state_q == S_MOVE_L) || (state_q == S_MOVE_R);
  assign move_tick  = moving && tick_q && (fdiv_q == FDIV_LAST);
  assign flash_done = (state_q == S_FLASH) && tick_q && (flash_q == FLASH_LAST);
  assign hit_ok     = hit && moving;
  assign x_ext      = {1'b0, x_q};

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = S_MOVE_L;
        S_MOVE_L: begin
          if (hit)                                state_d = (hp_q == 3'd1) ? S_DEAD : S_FLASH;
          else if (move_tick && (x_ext < L_EDGE)) state_d = S_MOVE_R;
        end
        S_MOVE_R: begin
          if (hit)                                                   state_d = (hp_q == 3'd1) ? S_DEAD : S_FLASH;
          else if (move_tick && (x_ext + R_REACH > 11'(X_MAX)))      state_d = S_MOVE_L;
        end
        S_FLASH:  if (flash_done) state_d = ret_q ? S_MOVE_L : S_MOVE_R;
        default:  state_d = state_q;
      endcase
    end
  end

  // Datapath next-state; hit outranks the movement tick, restart outranks everything.
  always_comb begin
    tick_d  = match && !match_q && !restart;
    fdiv_d  = fdiv_q;
    flash_d = flash_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    hp_d    = hp_q;
    vis_d   = vis_q;
    ret_d   = ret_q;
    if (restart) begin
      fdiv_d  = 4'd0;
      flash_d = 4'd0;
      x_d     = 10'(X_INIT);
      y_d     = 10'(Y_INIT);
      dir_d   = 1'b1;
      hp_d    = 3'(HP_INIT);
      vis_d   = 1'b1;
      ret_d   = 1'b1;
    end else begin
      if (hit_ok) begin
        hp_d    = hp_q - 3'd1;
        flash_d = 4'd0;
        ret_d   = (state_q == S_MOVE_L);
        if (hp_q == 3'd1) vis_d = 1'b0;
      end else if (move_tick) begin
        fdiv_d = 4'd0;
        if (state_q == S_MOVE_L) begin
          y_d = y_q + 10'(STEP_Y);
          if (x_ext < L_EDGE) begin
            x_d   = 10'(X_MIN);
            dir_d = 1'b0;
          end else begin
            x_d = x_q - 10'(STEP_X);
          end
        end else begin
          y_d = y_q - 10'(STEP_Y);
          if (x_ext + R_REACH > 11'(X_MAX)) begin
            x_d   = 10'(X_MAX - M_WIDTH);
            dir_d = 1'b1;
          end else begin
            x_d = x_q + 10'(STEP_X);
          end
        end
      end else if (moving && tick_q) begin
        fdiv_d = fdiv_q + 4'd1;
      end
      if ((state_q == S_IDLE) && start) fdiv_d = 4'd0;
      if ((state_q == S_FLASH) && tick_q) begin
        if (flash_done) begin
          vis_d  = 1'b1;
          fdiv_d = 4'd0;
        end else begin
          flash_d = flash_q + 4'd1;
          vis_d   = ~flash_d[0];
        end
      end
    end
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      tick_q  <= 1'b0;
      fdiv_q  <= 4'd0;
      flash_q <= 4'd0;
      x_q     <= 10'(X_INIT);
      y_q     <= 10'(Y_INIT);
      dir_q   <= 1'b1;
      hp_q    <= 3'(HP_INIT);
      vis_q   <= 1'b1;
      ret_q   <= 1'b1;
    end else begin
      match_q <= match;
      tick_q  <= tick_d;
      fdiv_q  <= fdiv_d;
      flash_q <= flash_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      hp_q    <= hp_d;
      vis_q   <= vis_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    M1X            = x_q;
    M1Y            = y_q;
    dir            = dir_q;
    hp             = hp_q;
    frame_tick     = tick_q;
    dead           = (state_q == S_DEAD);
    sprite_visible = vis_q && (state_q != S_DEAD);
  end

endmodule

// File: tb/tb_monster_motion_ctrl.sv
// tb/tb_monster_motion_ctrl.sv - directed self-checking bench for monster_motion_ctrl
module tb_monster_motion_ctrl;

  logic       Pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] xx = 10'd0, yy = 10'd0;
  logic       start = 1'b0, hit = 1'b0, restart = 1'b0;
  logic [9:0] M1X, M1Y;
  logic       dir, sprite_visible, dead, frame_tick;
  logic [2:0] hp;

  int n_cmp = 0;
  int n_bad = 0;

  monster_motion_ctrl dut (
    .Pclk(Pclk), .rst_n(rst_n), .xx(xx), .yy(yy),
    .start(start), .hit(hit), .restart(restart),
    .M1X(M1X), .M1Y(M1Y), .dir(dir), .hp(hp),
    .sprite_visible(sprite_visible), .dead(dead), .frame_tick(frame_tick)
  );

  always #20 Pclk = ~Pclk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame();
    @(negedge Pclk); xx = 10'd639; yy = 10'd479;
    @(negedge Pclk); xx = 10'd0;   yy = 10'd0;
    @(negedge Pclk);
    @(negedge Pclk);
  endtask

  task automatic mtick();
    repeat (3) frame();
  endtask

  task automatic pulse_start();
    @(negedge Pclk); start = 1'b1;
    @(negedge Pclk); start = 1'b0;
    @(negedge Pclk);
  endtask

  task automatic pulse_hit();
    @(negedge Pclk); hit = 1'b1;
    @(negedge Pclk); hit = 1'b0;
    @(negedge Pclk);
  endtask

  task automatic pulse_restart();
    @(negedge Pclk); restart = 1'b1;
    @(negedge Pclk); restart = 1'b0;
    @(negedge Pclk);
  endtask

  initial begin
    logic exp_vis [1:7];
    exp_vis[1] = 1'b0; exp_vis[2] = 1'b1; exp_vis[3] = 1'b0; exp_vis[4] = 1'b1;
    exp_vis[5] = 1'b0; exp_vis[6] = 1'b1; exp_vis[7] = 1'b0;

    repeat (3) @(negedge Pclk);
    rst_n = 1'b1;
    @(negedge Pclk);
    chk("rst_x", M1X, 135);
    chk("rst_y", M1Y, 85);
    chk("rst_dir", dir, 1);
    chk("rst_hp", hp, 3);
    chk("rst_vis", sprite_visible, 1);
    chk("rst_dead", dead, 0);
    chk("rst_ftick", frame_tick, 0);

    // held end-of-frame pixel yields a single strobe
    @(negedge Pclk); xx = 10'd639; yy = 10'd479;
    @(negedge Pclk); chk("ftick_on", frame_tick, 1);
    @(negedge Pclk); chk("ftick_held", frame_tick, 0);
    xx = 10'd0; yy = 10'd0;
    @(negedge Pclk);
    chk("idle_x", M1X, 135);

    pulse_start();
    frame(); chk("div1_x", M1X, 135);
    frame(); chk("div2_x", M1X, 135);
    frame();
    chk("div3_x", M1X, 125);
    chk("div3_y", M1Y, 95);
    chk("div3_dir", dir, 1);

    // hit lands on the same cycle as the completing frame_tick
    frame(); frame();
    @(negedge Pclk); xx = 10'd639; yy = 10'd479;
    @(negedge Pclk); xx = 10'd0; yy = 10'd0; hit = 1'b1;
    @(negedge Pclk); hit = 1'b0;
    chk("hittick_hp", hp, 2);
    chk("hittick_x", M1X, 125);
    chk("hittick_y", M1Y, 95);
    chk("flash_vis0", sprite_visible, 1);
    pulse_hit();
    chk("flash_hit_hp", hp, 2);

    for (int k = 1; k <= 7; k++) begin
      frame();
      chk($sformatf("flash_vis%0d", k), sprite_visible, exp_vis[k]);
      chk($sformatf("flash_x%0d", k), M1X, 125);
    end
    frame();
    chk("flash_end_vis", sprite_visible, 1);
    frame(); frame();
    chk("resume_x_hold", M1X, 125);
    frame();
    chk("resume_x", M1X, 115);
    chk("resume_y", M1Y, 105);
    chk("resume_dir", dir, 1);

    repeat (9) mtick();
    chk("left_x", M1X, 25);
    chk("left_y", M1Y, 195);
    mtick();
    chk("clampL_x", M1X, 23);
    chk("clampL_y", M1Y, 205);
    chk("clampL_dir", dir, 0);
    mtick();
    chk("right1_x", M1X, 33);
    chk("right1_y", M1Y, 195);
    chk("right1_dir", dir, 0);

    for (int k = 0; k < 57; k++) begin
      mtick();
      if (M1X > 10'd605) chk("right_bound", M1X, 605);
    end
    chk("right_x", M1X, 603);
    mtick();
    chk("clampR_x", M1X, 605);
    chk("clampR_dir", dir, 1);
    mtick();
    chk("back_left_x", M1X, 595);
    chk("back_left_dir", dir, 1);

    pulse_hit();
    chk("hit2_hp", hp, 1);
    chk("hit2_dead", dead, 0);
    repeat (8) frame();
    chk("hit2_x", M1X, 595);
    chk("hit2_vis", sprite_visible, 1);
    pulse_hit();
    chk("hit3_hp", hp, 0);
    chk("hit3_dead", dead, 1);
    chk("hit3_vis", sprite_visible, 0);
    mtick();
    chk("dead_x", M1X, 595);
    pulse_start();
    pulse_hit();
    chk("dead_stay", dead, 1);
    chk("dead_hp", hp, 0);

    pulse_restart();
    chk("rs_x", M1X, 135);
    chk("rs_y", M1Y, 85);
    chk("rs_hp", hp, 3);
    chk("rs_dir", dir, 1);
    chk("rs_dead", dead, 0);
    chk("rs_vis", sprite_visible, 1);
    mtick();
    chk("rs_idle_x", M1X, 135);

    pulse_start();
    pulse_hit();
    chk("mf_hp", hp, 2);
    frame();
    chk("mf_vis", sprite_visible, 0);
    @(negedge Pclk); rst_n = 1'b0;
    #1;
    chk("arst_hp", hp, 3);
    chk("arst_vis", sprite_visible, 1);
    chk("arst_x", M1X, 135);
    chk("arst_y", M1Y, 85);
    @(negedge Pclk); rst_n = 1'b1;
    mtick();
    chk("arst_idle_x", M1X, 135);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
